// File: rtl/td4_pkg.sv
// Shared types for the TD4 run/load controller: FSM state encoding, mode switch
// codes and program-memory geometry.
package td4_pkg;

  localparam int PMEM_DEPTH = 16;
  localparam int PMEM_AW    = 4;
  localparam int INSN_W     = 8;

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_STEP = 2'b01,
    MODE_RUN  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_HALT  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

  function automatic state_e mode_to_state(input mode_e m);
    state_e s;
    case (m)
      MODE_RUN:  s = ST_RUN;
      MODE_STEP: s = ST_STEP;
      MODE_LOAD: s = ST_LOAD;
      default:   s = ST_HALT;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/td4_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// registered one-cycle pulse on each accepted rising level.
module td4_debounce #(
  parameter int DEBOUNCE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where the synced input agrees with the accepted level restarts the count.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = sync2_q;
      else                   cnt_d    = cnt_q + 1'b1;
    end
    rise_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/td4_run_ctrl.sv
// TD4 execution and program-load controller: HALT / RUN / STEP / LOAD modes.
// Define TD4_BREAKPOINT_EN to enable the RUN breakpoint and the BREAK state.
module td4_run_ctrl
  import td4_pkg::*;
#(
  parameter int DIV      = 1_000_000,
  parameter int DEBOUNCE = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic        step_btn,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  input  logic [3:0]  ip,
  input  logic [3:0]  bp_addr,
  output logic        cpu_en,
  output logic        cpu_rst_n,
  output logic        mem_we,
  output logic [3:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  output logic [2:0]  state,
  output logic        load_done,
  output logic        bp_hit
);

  localparam int DIV_W  = $clog2(DIV);
  localparam int LCNT_W = PMEM_AW + 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [LCNT_W-1:0] LOAD_FULL = LCNT_W'(PMEM_DEPTH);

  mode_e               mode_s1_q, mode_s2_q;
  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
  logic                cpu_en_q, cpu_en_d;
  logic                cpu_rst_n_q, cpu_rst_n_d;
  logic                mem_we_q, mem_we_d;
  logic [PMEM_AW-1:0]  mem_addr_q, mem_addr_d;
  logic [INSN_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                load_done_q, load_done_d;
  logic                bp_hit_q, bp_hit_d;
  logic                step_rise, run_due, ld_ready_c, accept;

  td4_debounce #(.DEBOUNCE(DEBOUNCE)) u_step_db (
    .clk     (clock),
    .rst_n   (reset),
    .btn_raw (step_btn),
    .rise    (step_rise)
  );

`ifndef TD4_BREAKPOINT_EN
  logic unused_bp_inputs;
  assign unused_bp_inputs = ^{ip, bp_addr};
`endif

  // Loader handshake: a byte transfers on any cycle with ld_valid && ld_ready;
  // the loader holds ld_data stable until then. ld_ready drops one cycle before
  // LOAD is left so that every accepted byte is written while still in LOAD.
  always_comb begin
    state_d = mode_to_state(mode_s2_q);
    run_due = (state_q == ST_RUN) && (div_q == DIV_LAST);
`ifdef TD4_BREAKPOINT_EN
    if (state_q == ST_BREAK && mode_s2_q == MODE_RUN)
      state_d = ST_BREAK;
    else if (run_due && state_d == ST_RUN && ip == bp_addr)
      state_d = ST_BREAK;
`endif

    div_d = '0;
    if (state_q == ST_RUN && state_d == ST_RUN && !run_due) div_d = div_q + 1'b1;

    ld_ready_c = (state_q == ST_LOAD) && (state_d == ST_LOAD) && (lcnt_q != LOAD_FULL);
    accept     = ld_valid && ld_ready_c;
    lcnt_d     = (state_d == ST_LOAD) ? lcnt_q + LCNT_W'(accept) : '0;

    mem_we_d    = accept;
    mem_addr_d  = accept ? lcnt_q[PMEM_AW-1:0] : mem_addr_q;
    mem_wdata_d = accept ? ld_data : mem_wdata_q;
    load_done_d = (state_d == ST_LOAD) && (lcnt_d == LOAD_FULL);

    // Core restarts from ip=0 on the first cycle after LOAD; pulses only when staying put.
    cpu_rst_n_d = (state_d != ST_LOAD);
    cpu_en_d    = (run_due && state_d == ST_RUN) ||
                  (state_q == ST_STEP && state_d == ST_STEP && step_rise);
    bp_hit_d    = (state_d == ST_BREAK);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_s1_q   <= MODE_HALT;
      mode_s2_q   <= MODE_HALT;
      state_q     <= ST_HALT;
      div_q       <= '0;
      lcnt_q      <= '0;
      cpu_en_q    <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      load_done_q <= 1'b0;
      bp_hit_q    <= 1'b0;
    end else begin
      mode_s1_q   <= mode_e'(mode);
      mode_s2_q   <= mode_s1_q;
      state_q     <= state_d;
      div_q       <= div_d;
      lcnt_q      <= lcnt_d;
      cpu_en_q    <= cpu_en_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      load_done_q <= load_done_d;
      bp_hit_q    <= bp_hit_d;
    end
  end

  assign ld_ready  = ld_ready_c;
  assign cpu_en    = cpu_en_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign state     = state_q;
  assign load_done = load_done_q;
  assign bp_hit    = bp_hit_q;

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Bench for td4_run_ctrl (DIV=4, DEBOUNCE=4): directed sequence with random
// gaps/holds, checked against a cycle-level model of the expected pulses and writes.
module tb_td4_run_ctrl;
  import td4_pkg::*;

  localparam int DIV = 4;
  localparam int DEB = 4;
`ifdef TD4_BREAKPOINT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       step_btn = 1'b0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = 8'h00;
  logic [3:0] ip;
  logic [3:0] bp_addr = 4'd7;
  logic       ld_ready, cpu_en, cpu_rst_n, mem_we, load_done, bp_hit;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit core_on = 1'b0;
  logic [27:0] exp_q[$];
  int en_log[$];
  int exp_en[$];

  td4_run_ctrl #(.DIV(DIV), .DEBOUNCE(DEB)) dut (
    .clock(clock), .reset(reset), .mode(mode), .step_btn(step_btn),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ip(ip), .bp_addr(bp_addr), .cpu_en(cpu_en), .cpu_rst_n(cpu_rst_n),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .state(state), .load_done(load_done), .bp_hit(bp_hit)
  );

  // ---------------- clock / reset / core model ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock or negedge reset) begin
    if (!reset)                 ip <= 4'd0;
    else if (!cpu_rst_n)        ip <= 4'd0;
    else if (cpu_en && core_on) ip <= ip + 4'd1;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (cpu_en) en_log.push_back(cyc);
    check("inv_en_excl", 32'(cpu_en && (!cpu_rst_n || mem_we)), 32'd0);
    check("inv_we_load", 32'(mem_we && (state != 3'(ST_LOAD))), 32'd0);
    if (mem_we) begin
      if (exp_q.size() == 0) check("we_unexpected", 32'(exp_q.size()), 32'd1);
      else check("mem_write", {4'h0, cyc[15:0], mem_addr, mem_wdata}, {4'h0, exp_q.pop_front()});
    end
  end

  task automatic check_pulses(input string tag);
    check({tag, "_count"}, 32'(en_log.size()), 32'(exp_en.size()));
    for (int i = 0; i < exp_en.size() && i < en_log.size(); i++)
      check({tag, "_cycle"}, 32'(en_log[i]), 32'(exp_en[i]));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},     32'(state),     32'(ST_HALT));
    check({tag, "_cpu_en"},    32'(cpu_en),    32'd0);
    check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    check({tag, "_ld_ready"},  32'(ld_ready),  32'd0);
    check({tag, "_mem_we"},    32'(mem_we),    32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_bp_hit"},    32'(bp_hit),    32'd0);
  endtask

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] next_byte(input int idx);
    if (idx == 0) return 8'h3C;
    if (idx == 1) return 8'h36;
    return 8'($urandom);
  endfunction

  // Streams nbytes with random valid gaps; every accepted byte is expected as a
  // write of (running index, byte) on the following cycle.
  task automatic load_bytes(input int nbytes);
    int acc;
    logic [7:0] cur;
    acc = 0;
    cur = next_byte(0);
    for (int it = 0; it < 1000 && acc < nbytes; it++) begin
      ld_data  = cur;
      ld_valid = ($urandom_range(0, 3) != 0);
      check("ld_ready", 32'(ld_ready), 32'd1);
      check("load_rst_n", 32'(cpu_rst_n), 32'd0);
      if (ld_valid) begin
        exp_q.push_back({16'(cyc + 1), 4'(acc), cur});
        acc++;
        cur = next_byte(acc);
      end
      tick(1);
    end
    ld_valid = 1'b0;
    check("load_count", 32'(acc), 32'(nbytes));
  endtask

  // RUN window: pulses expected at 3 + DIV*(j+1) edges after the mode change,
  // while the synced mode still says RUN, stopping at a breakpoint if enabled.
  task automatic run_window(input string tag, input int hold, input bit with_core);
    int c0, c1, e, ip_m;
    bit hit;
    en_log.delete();
    exp_en.delete();
    core_on = with_core;
    mode = 2'b10;
    c0 = cyc;
    tick(hold);
    c1 = cyc;
    hit = 1'b0;
    ip_m = 0;
    for (int j = 0; j < 1000; j++) begin
      e = c0 + 3 + DIV * (j + 1);
      if (e > c1 + 2) break;
      if (BP_EN && with_core && (ip_m % 16) == int'(bp_addr)) begin
        hit = 1'b1;
        break;
      end
      exp_en.push_back(e);
      ip_m++;
    end
    check({tag, "_state"}, 32'(state), hit ? 32'(ST_BREAK) : 32'(ST_RUN));
    check({tag, "_bp_hit"}, 32'(bp_hit), 32'(hit));
    mode = 2'b00;
    tick(6);
    check_pulses(tag);
    check({tag, "_exit_state"}, 32'(state), 32'(ST_HALT));
    check({tag, "_exit_bp_hit"}, 32'(bp_hit), 32'd0);
    core_on = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int p, g;
    #1 reset = 1'b0;
    tick(3);
    check_reset_values("por");
    reset = 1'b1;
    tick(1);
    check("rst_release_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    check("rst_release_state", 32'(state), 32'(ST_HALT));
    en_log.delete();
    tick(1000);
    check("halt_no_pulse", 32'(en_log.size()), 32'd0);

    run_window("run_a", $urandom_range(20, 40), 1'b0);
    run_window("run_b", $urandom_range(20, 40), 1'b0);

    // STEP: glitches never pulse; each clean (possibly bounced) press pulses once.
    mode = 2'b01;
    tick(3);
    check("step_state", 32'(state), 32'(ST_STEP));
    en_log.delete();
    exp_en.delete();
    for (int k = 0; k < 4; k++) begin
      g = $urandom_range(1, DEB - 1);
      step_btn = 1'b1;
      tick(g);
      step_btn = 1'b0;
      tick($urandom_range(8, 12));
      if (k % 2 == 1) begin
        step_btn = 1'b1;
        tick($urandom_range(1, DEB - 1));
        step_btn = 1'b0;
        tick(1);
      end
      step_btn = 1'b1;
      p = cyc;
      exp_en.push_back(p + 2 + DEB + 1);
      tick((k == 0) ? 50 : $urandom_range(10, 30));
      step_btn = 1'b0;
      tick($urandom_range(10, 16));
    end
    check_pulses("step");

    // Full 16-byte load.
    mode = 2'b11;
    tick(3);
    check("load_state", 32'(state), 32'(ST_LOAD));
    load_bytes(16);
    check("load_full_ready", 32'(ld_ready), 32'd0);
    check("load_full_done", 32'(load_done), 32'd1);
    tick(1);
    check("load_full_drained", 32'(exp_q.size()), 32'd0);
    mode = 2'b00;
    tick(2);
    check("load_hold_state", 32'(state), 32'(ST_LOAD));
    check("load_hold_rst_n", 32'(cpu_rst_n), 32'd0);
    check("load_hold_done", 32'(load_done), 32'd1);
    tick(1);
    check("load_exit_state", 32'(state), 32'(ST_HALT));
    check("load_exit_rst_n", 32'(cpu_rst_n), 32'd1);
    check("load_exit_done", 32'(load_done), 32'd0);

    // Aborted load after 5 bytes, then re-entry restarts at address 0.
    mode = 2'b11;
    tick(3);
    load_bytes(5);
    mode = 2'b00;
    tick(4);
    check("abort_state", 32'(state), 32'(ST_HALT));
    check("abort_done", 32'(load_done), 32'd0);
    check("abort_drained", 32'(exp_q.size()), 32'd0);
    mode = 2'b11;
    tick(3);
    check("reload_done", 32'(load_done), 32'd0);
    load_bytes(3);
    check("reload_done_partial", 32'(load_done), 32'd0);

    // Asynchronous reset in the middle of the load.
    #2 reset = 1'b0;
    #1;
    check_reset_values("midload");
    exp_q.delete();
    tick(2);
    reset = 1'b1;
    tick(1);
    check("postrst_rst_n", 32'(cpu_rst_n), 32'd1);
    tick(2);
    check("postrst_state", 32'(state), 32'(ST_LOAD));
    check("postrst_rst_n_load", 32'(cpu_rst_n), 32'd0);
    load_bytes(2);
    tick(2);
    check("postrst_drained", 32'(exp_q.size()), 32'd0);
    check("postrst_done", 32'(load_done), 32'd0);
    mode = 2'b00;
    tick(4);

    // Breakpoint at ip=7 with a core that advances on each cpu_en.
    check("bp_ip_start", 32'(ip), 32'd0);
    run_window("bp", 60, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/td4_run_ctrl.md
# td4_run_ctrl

Execution and program-load controller for the TD4 4-bit CPU core. It drives the core's clock enable and reset, and runs the core free (divided rate), single-stepped from a push button, or halted. It also writes the 16×8 program memory from a byte-stream loader over a valid/ready handshake. It sits between board switches/buttons and the core plus its program memory.

## Interface
- `DIV`, 1_000_000 — clock cycles per instruction in RUN; legal range ≥2
- `DEBOUNCE`, 16 — cycles `step_btn` must be stable before a level is accepted; ≥1
- `clock`  in  1  — single system clock, rising edge
- `reset`  in  1  — asynchronous, active-low reset
- `mode`  in  2  — raw switch input: 00 HALT, 01 STEP, 10 RUN, 11 LOAD
- `step_btn`  in  1  — raw push button, active-high
- `ld_valid`  in  1  — loader byte valid
- `ld_data`  in  8  — loader byte (opcode[7:4], imm[3:0])
- `ld_ready`  out  1  — controller accepts a byte this cycle
- `ip`  in  4  — core instruction pointer
- `bp_addr`  in  4  — breakpoint address
- `cpu_en`  out  1  — one-cycle core clock enable
- `cpu_rst_n`  out  1  — core reset, active-low
- `mem_we`  out  1  — program memory write strobe
- `mem_addr`  out  4  — program memory write address
- `mem_wdata`  out  8  — program memory write data
- `state`  out  3  — current FSM state (encoding in package)
- `load_done`  out  1  — all 16 bytes written
- `bp_hit`  out  1  — halted on breakpoint

## Operation
- `mode` passes through a 2-flop synchronizer. `step_btn` passes through a 2-flop synchronizer, then a debouncer. All decisions use the synchronized/debounced values.
- FSM states: HALT, RUN, STEP, LOAD, BREAK.
  - Next state follows synced `mode` each cycle.
  - Exception: BREAK holds until synced `mode` differs from RUN.
- HALT: `cpu_en`=0, core held in its current state.
- RUN:
  - Divider counts 0..DIV-1.
  - At count DIV-1, `cpu_en`=1 for one cycle and the count wraps to 0.
  - Divider clears on every entry to RUN.
- STEP: each debounced rising edge of `step_btn` yields exactly one `cpu_en` pulse. A held button never repeats.
- LOAD:
  - `cpu_rst_n`=0 throughout.
  - Address counter starts at 0. `ld_ready`=1 while fewer than 16 bytes are accepted.
  - Handshake: a byte is accepted on a cycle where `ld_valid`&&`ld_ready`. The loader holds `ld_data` until accepted.
  - Each accepted byte produces `mem_we`=1 on the next cycle, with `mem_addr`/`mem_wdata` registered. The counter then increments.
  - After the 16th accept: `ld_ready`=0, and `load_done`=1 until LOAD is exited.
  - Leaving LOAD early aborts the load: counter→0, `load_done`=0, bytes already written are kept.
- Leaving LOAD: `cpu_rst_n`=1 on the first cycle in the new state, so the core restarts at `ip`=0.
- Invariants:
  - `cpu_en` is never 1 while `cpu_rst_n`=0 or `mem_we`=1.
  - `mem_we` is only ever 1 in LOAD.

## Timing
- Reset values: state=HALT, `cpu_en`=0, `cpu_rst_n`=0, `ld_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `load_done`=0, `bp_hit`=0; divider, counters and synchronizers cleared.
- `cpu_rst_n` rises on the first clock edge after `reset` deasserts, unless synced `mode` is LOAD.
- `mode` change → state change: 3 cycles (2 sync + 1 register).
- `step_btn` edge → `cpu_en`: 2 + DEBOUNCE + 1 cycles, with the button stable throughout. Any bounce restarts the DEBOUNCE count.
- Byte accept → `mem_we`: 1 cycle. Full throughput is one byte per cycle.
- `reset` asserted mid-load or mid-run: all outputs go to reset values immediately (asynchronous). The load restarts from address 0.

## Configuration
- `TD4_BREAKPOINT_EN` defined:
  - In RUN, on the cycle a `cpu_en` pulse is due and `ip`==`bp_addr`, the pulse is suppressed.
  - FSM enters BREAK with `bp_hit`=1.
  - BREAK is left only by a synced `mode` other than RUN, which clears `bp_hit`.
  - STEP ignores breakpoints.
- Undefined: `bp_addr` is ignored, `bp_hit` is tied 0, and BREAK is unreachable.

## Structure
- Package `td4_pkg` holds:
  - state enum (HALT, RUN, STEP, LOAD, BREAK)
  - mode codes
  - `PMEM_DEPTH`=16, `PMEM_AW`=4, `INSN_W`=8
- Sub-module `td4_debounce`: 2-flop synchronizer, stability counter of width $clog2(DEBOUNCE+1), and a registered rising-edge pulse output. It is instantiated once, for `step_btn`.

## Test plan
- Reset release, `mode`=00 → `cpu_rst_n`=1 after one edge; `cpu_en` stays 0 for 1000 cycles.
- `DIV`=4, `mode`=10 → `cpu_en` pulses every 4 cycles; first pulse 3+4 cycles after the mode change.
- `mode`=01, `DEBOUNCE`=4:
  - clean press held 50 cycles → exactly one `cpu_en` pulse, 7 cycles after the press;
  - a glitch shorter than 4 cycles → no pulse.
- `mode`=11, loader streams 0x3C,0x36,…, 16 bytes with random `ld_valid` gaps:
  - `mem_we`/`mem_addr` 0..15 carry the matching data;
  - `load_done`=1 and `ld_ready`=0 after the 16th byte;
  - `cpu_rst_n`=0 throughout.
- LOAD aborted after 5 bytes, then re-entered → writes restart at `mem_addr`=0 and `load_done`=0. Assert `reset` mid-load → all outputs return to reset values the same cycle.
- `TD4_BREAKPOINT_EN`, `bp_addr`=7, `mode`=10 → the pulse due with `ip`=7 is suppressed, state=BREAK, `bp_hit`=1. `mode`→00 clears `bp_hit`.
